// File: rtl/req_arbiter4.sv
// req_arbiter4: 4-way request arbiter, registered one-hot grant, hold limit.
// Define REQ_ARBITER4_ROUND_ROBIN_EN for round-robin winner selection.
module req_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       gnt_idx_q, gnt_idx_d;
  logic             timeout_q, timeout_d;

  logic [3:0] ereq;
  logic [3:0] mask_set;
  logic [1:0] win_idx;
  logic       start;
  logic       owner_req;
  logic       at_limit;

  assign ereq      = req & ~mask_q;
  assign start     = enable && (ereq != 4'b0000);
  assign owner_req = req[gnt_idx_q];
  assign at_limit  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

`ifdef REQ_ARBITER4_ROUND_ROBIN_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] cand;
  logic       found;

  // Search downward from rr_ptr-1, wrapping; rr_ptr itself is tried last.
  always_comb begin
    win_idx = rr_ptr_q;
    cand    = rr_ptr_q;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_ptr_q - 2'(k);
      if (!found && ereq[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == IDLE && start)
      rr_ptr_d = win_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= 2'd3;
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    priority case (1'b1)
      ereq[3]: win_idx = 2'd3;
      ereq[2]: win_idx = 2'd2;
      ereq[1]: win_idx = 2'd1;
      default: win_idx = 2'd0;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      mask_q     <= 4'b0000;
      gnt_q      <= 4'b0000;
      gnt_idx_q  <= 2'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      mask_q     <= mask_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = GRANT;
      GRANT:   if (!owner_req || at_limit) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A release in the limit cycle wins over the timeout.
  always_comb begin
    gnt_d      = 4'b0000;
    gnt_idx_d  = gnt_idx_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    mask_set   = 4'b0000;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          gnt_d      = 4'b0001 << win_idx;
          gnt_idx_d  = win_idx;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          gnt_d = 4'b0000;
        end else if (at_limit) begin
          timeout_d           = 1'b1;
          mask_set[gnt_idx_q] = 1'b1;
        end else begin
          gnt_d = gnt_q;
          if (hold_cnt_q != CNT_MAX)
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        gnt_d = 4'b0000;
      end
    endcase
    mask_d = (mask_q & req) | mask_set;
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_req_arbiter4.sv
// tb_req_arbiter4: directed stimulus, cycle model check of two arbiters
// (hold limit 8 and hold limit disabled) plus hand-computed checkpoints.
module tb_req_arbiter4;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] req;

  logic [3:0] gnt8, gnt0;
  logic [1:0] idx8, idx0;
  logic       val8, val0;
  logic       to8, to0;

  int tests = 0;
  int fails = 0;

  req_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .enable(enable), .req(req),
    .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(val8), .timeout(to8)
  );

  req_arbiter4 #(.MAX_HOLD(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .req(req),
    .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(val0), .timeout(to0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // owner < 0 means free; cool counts the cycles still to wait before arbitrating
  typedef struct {
    int       owner;
    int       held;
    int       cool;
    bit [3:0] mask;
    int       rr;
    int       idx;
    bit       to;
  } mdl_t;

  localparam mdl_t MDL_RST = '{owner: -1, held: 0, cool: 0,
                               mask: 4'b0000, rr: 3, idx: 0, to: 1'b0};

  mdl_t m8, m0;

  function automatic int pick(bit [3:0] e, int rr);
`ifdef REQ_ARBITER4_ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (rr - k + 8) % 4;
      if (e[j]) return j;
    end
`else
    for (int j = 3; j >= 0; j--)
      if (e[j]) return j + (rr * 0);
`endif
    return -1;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit [3:0] r, bit en, int mh);
    mdl_t n;
    n    = m;
    n.to = 1'b0;
    for (int i = 0; i < 4; i++)
      if (!r[i]) n.mask[i] = 1'b0;
    if (m.owner >= 0) begin
      if (!r[m.owner]) begin
        n.owner = -1;
        n.cool  = 1;
      end else if (mh != 0 && m.held == mh) begin
        n.owner         = -1;
        n.cool          = 1;
        n.to            = 1'b1;
        n.mask[m.owner] = 1'b1;
      end else begin
        n.held = m.held + 1;
      end
    end else if (m.cool > 0) begin
      n.cool = m.cool - 1;
    end else if (en && ((r & ~m.mask) != 4'b0000)) begin
      n.owner = pick(r & ~m.mask, m.rr);
      n.held  = 1;
      n.idx   = n.owner;
      n.rr    = n.owner;
    end
    return n;
  endfunction

  function automatic logic [3:0] mgnt(mdl_t m);
    return (m.owner >= 0) ? (4'b0001 << m.owner) : 4'b0000;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m8 <= MDL_RST;
      m0 <= MDL_RST;
    end else begin
      m8 <= mstep(m8, req, enable, 8);
      m0 <= mstep(m0, req, enable, 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("m8_gnt", {28'd0, gnt8}, {28'd0, mgnt(m8)});
    chk("m8_idx", {30'd0, idx8}, m8.idx);
    chk("m8_val", {31'd0, val8}, {31'd0, m8.owner >= 0});
    chk("m8_to", {31'd0, to8}, {31'd0, m8.to});
    chk("m0_gnt", {28'd0, gnt0}, {28'd0, mgnt(m0)});
    chk("m0_idx", {30'd0, idx0}, m0.idx);
    chk("m0_val", {31'd0, val0}, {31'd0, m0.owner >= 0});
    chk("m0_to", {31'd0, to0}, {31'd0, m0.to});
    chk("onehot8", {31'd0, $onehot0(gnt8)}, 32'd1);
    chk("valid8", {31'd0, val8}, {31'd0, |gnt8});
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int exp_rr[5];
  int w;

  initial begin
`ifdef REQ_ARBITER4_ROUND_ROBIN_EN
    exp_rr = '{2, 1, 0, 3, 2};
`else
    exp_rr = '{3, 3, 3, 3, 3};
`endif
    rst    = 1'b1;
    enable = 1'b0;
    req    = 4'b0000;
    #3;
    chk("rst_gnt", {28'd0, gnt8}, 32'd0);
    chk("rst_idx", {30'd0, idx8}, 32'd0);
    chk("rst_val", {31'd0, val8}, 32'd0);
    chk("rst_to", {31'd0, to8}, 32'd0);
    tick(1);
    rst = 1'b0;

    // basic grant, release, two-cycle gap
    enable = 1'b1;
    req    = 4'b0101;
    tick(1); #1;
    chk("basic_gnt", {28'd0, gnt8}, 32'h4);
    chk("basic_idx", {30'd0, idx8}, 32'd2);
    req = 4'b0001;
    tick(1); #1;
    chk("gap_gnt", {28'd0, gnt8}, 32'h0);
    tick(1); #1;
    chk("idle_gnt", {28'd0, gnt8}, 32'h0);
    tick(1); #1;
    chk("second_gnt", {28'd0, gnt8}, 32'h1);
    chk("second_idx", {30'd0, idx8}, 32'd0);
    req = 4'b0000;
    tick(3);

    // hold limit, masking, and re-arming by dropping the request
    req = 4'b1111;
    tick(1); #1;
`ifndef REQ_ARBITER4_ROUND_ROBIN_EN
    chk("hold_c1", {28'd0, gnt8}, 32'h8);
`endif
    tick(7); #1;
`ifndef REQ_ARBITER4_ROUND_ROBIN_EN
    chk("hold_c8", {28'd0, gnt8}, 32'h8);
    chk("hold_c8_to", {31'd0, to8}, 32'd0);
`endif
    tick(1); #1;
    chk("limit_gnt", {28'd0, gnt8}, 32'h0);
    chk("limit_to", {31'd0, to8}, 32'd1);
    tick(1); #1;
    chk("to_pulse_end", {31'd0, to8}, 32'd0);
    tick(1); #1;
`ifndef REQ_ARBITER4_ROUND_ROBIN_EN
    chk("masked_gnt", {28'd0, gnt8}, 32'h4);
`endif
    req = 4'b0111;
    tick(1);
    req = 4'b1111;
    tick(1);
    req = 4'b1011;
    tick(1); #1;
`ifndef REQ_ARBITER4_ROUND_ROBIN_EN
    chk("rel_gnt", {28'd0, gnt8}, 32'h0);
`endif
    tick(2); #1;
`ifndef REQ_ARBITER4_ROUND_ROBIN_EN
    chk("rewin_gnt", {28'd0, gnt8}, 32'h8);
`endif
    req = 4'b0000;
    tick(12);

    // enable gating
    enable = 1'b0;
    req    = 4'b0010;
    tick(5); #1;
    chk("en0_gnt", {28'd0, gnt8}, 32'h0);
    enable = 1'b1;
    tick(1); #1;
    chk("en1_gnt", {28'd0, gnt8}, 32'h2);
    enable = 1'b0;
    tick(4); #1;
    chk("en_mid_gnt", {28'd0, gnt8}, 32'h2);
    req = 4'b0000;
    tick(1); #1;
    chk("en_rel_gnt", {28'd0, gnt8}, 32'h0);
    tick(2);

    // asynchronous reset in the middle of a grant
    enable = 1'b1;
    req    = 4'b0100;
    tick(1); #1;
    chk("pre_rst_gnt", {28'd0, gnt8}, 32'h4);
    rst = 1'b1;
    #1;
    chk("arst_gnt", {28'd0, gnt8}, 32'h0);
    chk("arst_val", {31'd0, val8}, 32'd0);
    chk("arst_to", {31'd0, to8}, 32'd0);
    req = 4'b0000;
    tick(1);
    rst = 1'b0;
    tick(1);
    req = 4'b1000;
    tick(1); #1;
    chk("post_rst_gnt", {28'd0, gnt8}, 32'h8);
    req = 4'b0000;
    tick(3);

    // owners release after two cycles and reassert
    req = 4'b1111;
    for (int e = 0; e < 5; e++) begin
      w = 0;
      while (!val8 && w < 12) begin
        tick(1);
        w++;
      end
      #1;
      chk("order_wait", {31'd0, val8}, 32'd1);
      chk("order_idx", {30'd0, idx8}, exp_rr[e]);
      tick(1);
      req = 4'b1111 & ~(4'b0001 << idx8);
      tick(1);
      req = 4'b1111;
    end
    req = 4'b0000;
    tick(4);

    // unlimited hold versus limit of 8 with a continuously held request
    req = 4'b0001;
    tick(1);
    for (int i = 0; i < 100; i++) begin
      #1;
      chk("nolim_gnt", {28'd0, gnt0}, 32'h1);
      chk("nolim_to", {31'd0, to0}, 32'd0);
      tick(1);
    end
    #1;
    chk("lim_masked_gnt", {28'd0, gnt8}, 32'h0);
    req = 4'b0000;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
